// File: rtl/qsfp_seq_pkg.sv
// Shared encodings, default timing and pin-state decode for the QSFP link sequencer.
package qsfp_seq_pkg;

  typedef enum logic [2:0] {
    ST_ABSENT     = 3'd0,
    ST_REFCLK_RST = 3'd1,
    ST_MOD_RST    = 3'd2,
    ST_MOD_INIT   = 3'd3,
    ST_PHY_START  = 3'd4,
    ST_UP         = 3'd5,
    ST_FAULT      = 3'd6
  } state_e;

  // Default cycle counts for a 100 MHz clock.
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 1000;
  localparam int unsigned DEF_REFCLK_RST_CYCLES = 100;
  localparam int unsigned DEF_MOD_RST_CYCLES    = 1000;
  localparam int unsigned DEF_INIT_CYCLES       = 200000000;
  localparam int unsigned DEF_LOCK_CYCLES       = 100000000;
  localparam int unsigned DEF_MAX_RETRY         = 3;
  localparam logic        DEF_LPMODE_RUN        = 1'b0;
  localparam int unsigned DEF_CNT_W             = 32;

  typedef struct packed {
    logic resetl;
    logic lpmode;
    logic modsell;
    logic refclk_reset;
    logic clock_ok;
  } pins_t;

  localparam pins_t PINS_ABSENT = '{resetl: 1'b0, lpmode: 1'b1, modsell: 1'b1,
                                    refclk_reset: 1'b1, clock_ok: 1'b0};

  // Cage/PHY pin levels held while the sequencer sits in a given state.
  function automatic pins_t state_pins(input state_e st, input logic lpmode_run);
    pins_t p;
    p = PINS_ABSENT;
    case (st)
      ST_MOD_RST: p.refclk_reset = 1'b0;
      ST_MOD_INIT: begin
        p.refclk_reset = 1'b0;
        p.resetl       = 1'b1;
      end
      ST_PHY_START, ST_UP: begin
        p.refclk_reset = 1'b0;
        p.resetl       = 1'b1;
        p.lpmode       = lpmode_run;
        p.modsell      = 1'b0;
        p.clock_ok     = 1'b1;
      end
      ST_FAULT: p.refclk_reset = 1'b0;
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/qsfp_debounce.sv
// Two-flop synchroniser with an optional stability filter. With STABLE_CYCLES <= 1
// the synchronised level is passed straight through.
module qsfp_debounce #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter logic        SYNC_RST      = 1'b1,
  parameter logic        INVERT        = 1'b0
) (
  input  logic clock_i,
  input  logic resetn_i,
  input  logic async_i,
  output logic level_o
);

  logic [1:0] sync_q;
  logic       level_s;

  // Metastability guard for the asynchronous sideband pin.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) sync_q <= {2{SYNC_RST}};
    else           sync_q <= {sync_q[0], async_i};
  end

  assign level_s = sync_q[1] ^ INVERT;

  if (STABLE_CYCLES <= 1) begin : g_bypass
    assign level_o = level_s;
  end else begin : g_filter
    localparam logic             RST_LVL = SYNC_RST ^ INVERT;
    localparam logic [CNT_W-1:0] LOAD    = CNT_W'(STABLE_CYCLES - 1);

    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Down-count while the input disagrees with the output; any agreement restarts it.
    always_comb begin
      out_d = out_q;
      cnt_d = cnt_q;
      if (level_s == out_q) begin
        cnt_d = LOAD;
      end else if (cnt_q == '0) begin
        out_d = ~out_q;
        cnt_d = LOAD;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    // Filter state register.
    always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
        out_q <= RST_LVL;
        cnt_q <= LOAD;
      end else begin
        out_q <= out_d;
        cnt_q <= cnt_d;
      end
    end

    assign level_o = out_q;
  end

endmodule

// File: rtl/qsfp_link_sequencer.sv
// QSFP28 cage power-up / reset / link bring-up sequencer.
//
// state        | meaning
// ABSENT       | no module; cage held in reset, refclk synthesiser in reset
// REFCLK_RST   | module seen; refclk synthesiser reset pulse
// MOD_RST      | module reset (resetl low)
// MOD_INIT     | reset released; module initialisation wait
// PHY_START    | module selected, PHY released; waiting for block lock
// UP           | link locked; later loss of lock is status only
// FAULT        | lock retries exhausted; waits for retry_clear
module qsfp_link_sequencer
  import qsfp_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REFCLK_RST_CYCLES = DEF_REFCLK_RST_CYCLES,
  parameter int unsigned MOD_RST_CYCLES    = DEF_MOD_RST_CYCLES,
  parameter int unsigned INIT_CYCLES       = DEF_INIT_CYCLES,
  parameter int unsigned LOCK_CYCLES       = DEF_LOCK_CYCLES,
  parameter int unsigned MAX_RETRY         = DEF_MAX_RETRY,
  parameter logic        LPMODE_RUN        = DEF_LPMODE_RUN,
  parameter int unsigned CNT_W             = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       qsfp_modprsl,
  input  logic       qsfp_intl,
  input  logic       phy_lock,
  input  logic       int_clear,
  input  logic       retry_clear,
  output logic       qsfp_resetl,
  output logic       qsfp_lpmode,
  output logic       qsfp_modsell,
  output logic       qsfp_refclk_reset,
  output logic       clock_ok,
  output logic       int_pending,
  output logic       present,
  output logic [2:0] state,
  output logic [1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] REFCLK_LOAD = CNT_W'(REFCLK_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MODRST_LOAD = CNT_W'(MOD_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LOAD   = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);

  logic present_s, intl_s, lock_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       retry_q, retry_d;
  logic             int_q, int_d;
  pins_t            pins_q;

  qsfp_debounce #(.CNT_W(CNT_W), .STABLE_CYCLES(DEBOUNCE_CYCLES), .SYNC_RST(1'b1), .INVERT(1'b1))
    u_prs  (.clock_i(clock), .resetn_i(resetn), .async_i(qsfp_modprsl), .level_o(present_s));
  qsfp_debounce #(.CNT_W(CNT_W), .STABLE_CYCLES(1), .SYNC_RST(1'b1), .INVERT(1'b0))
    u_intl (.clock_i(clock), .resetn_i(resetn), .async_i(qsfp_intl), .level_o(intl_s));
  qsfp_debounce #(.CNT_W(CNT_W), .STABLE_CYCLES(1), .SYNC_RST(1'b0), .INVERT(1'b0))
    u_lock (.clock_i(clock), .resetn_i(resetn), .async_i(phy_lock), .level_o(lock_s));

  // Next state, shared timer and retry count; removal overrides everything.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    if (state_q != ST_ABSENT && !present_s) begin
      state_d = ST_ABSENT;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_ABSENT: if (present_s) begin
          state_d = ST_REFCLK_RST;
          timer_d = REFCLK_LOAD;
        end
        ST_REFCLK_RST: if (timer_q == '0) begin
          state_d = ST_MOD_RST;
          timer_d = MODRST_LOAD;
        end else timer_d = timer_q - CNT_W'(1);
        ST_MOD_RST: if (timer_q == '0) begin
          state_d = ST_MOD_INIT;
          timer_d = INIT_LOAD;
        end else timer_d = timer_q - CNT_W'(1);
        ST_MOD_INIT: if (timer_q == '0) begin
          state_d = ST_PHY_START;
          timer_d = LOCK_LOAD;
        end else timer_d = timer_q - CNT_W'(1);
        ST_PHY_START: if (lock_s) begin
          state_d = ST_UP;
          retry_d = '0;
        end else if (timer_q == '0) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            state_d = ST_MOD_RST;
            timer_d = MODRST_LOAD;
          end else begin
            state_d = ST_FAULT;
          end
        end else timer_d = timer_q - CNT_W'(1);
        ST_UP: ;
        ST_FAULT: if (retry_clear) begin
          retry_d = '0;
          state_d = ST_MOD_RST;
          timer_d = MODRST_LOAD;
        end
        default: state_d = ST_ABSENT;
      endcase
    end
  end

  // Sticky interrupt: a new set beats a same-cycle clear; dropping to ABSENT wipes it.
  always_comb begin
    int_d = int_q;
    if (state_d == ST_ABSENT)                                         int_d = 1'b0;
    else if (!intl_s && (state_q == ST_PHY_START || state_q == ST_UP)) int_d = 1'b1;
    else if (int_clear)                                                int_d = 1'b0;
  end

  // State, timer and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_ABSENT;
      timer_q <= '0;
      retry_q <= '0;
      int_q   <= 1'b0;
      pins_q  <= PINS_ABSENT;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      int_q   <= int_d;
      pins_q  <= state_pins(state_d, LPMODE_RUN);
    end
  end

  assign qsfp_resetl       = pins_q.resetl;
  assign qsfp_lpmode       = pins_q.lpmode;
  assign qsfp_modsell      = pins_q.modsell;
  assign qsfp_refclk_reset = pins_q.refclk_reset;
  assign clock_ok          = pins_q.clock_ok;
  assign int_pending       = int_q;
  assign present           = present_s;
  assign state             = state_q;
  assign retry_cnt         = retry_q;

endmodule

// File: tb/tb_qsfp_link_sequencer.sv
// Scoreboard bench for qsfp_link_sequencer: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_qsfp_link_sequencer;

  logic       clock = 1'b0;
  logic       resetn, qsfp_modprsl, qsfp_intl, phy_lock, int_clear, retry_clear;
  logic       qsfp_resetl, qsfp_lpmode, qsfp_modsell, qsfp_refclk_reset, clock_ok;
  logic       int_pending, present;
  logic [2:0] state;
  logic [1:0] retry_cnt;

  always #5 clock = ~clock;

  qsfp_link_sequencer #(
    .DEBOUNCE_CYCLES(4), .REFCLK_RST_CYCLES(3), .MOD_RST_CYCLES(5),
    .INIT_CYCLES(10), .LOCK_CYCLES(8), .MAX_RETRY(2), .LPMODE_RUN(1'b0), .CNT_W(32)
  ) dut (
    .clock(clock), .resetn(resetn), .qsfp_modprsl(qsfp_modprsl), .qsfp_intl(qsfp_intl),
    .phy_lock(phy_lock), .int_clear(int_clear), .retry_clear(retry_clear),
    .qsfp_resetl(qsfp_resetl), .qsfp_lpmode(qsfp_lpmode), .qsfp_modsell(qsfp_modsell),
    .qsfp_refclk_reset(qsfp_refclk_reset), .clock_ok(clock_ok), .int_pending(int_pending),
    .present(present), .state(state), .retry_cnt(retry_cnt)
  );

  // Observed word: resetl lpmode modsell refclk_reset clock_ok | int | present | state | retry
  logic [11:0] obs;
  assign obs = {qsfp_resetl, qsfp_lpmode, qsfp_modsell, qsfp_refclk_reset, clock_ok,
                int_pending, present, state, retry_cnt};

  localparam logic [11:0] M_PINS = 12'hF80;
  localparam logic [11:0] M_INT  = 12'h040;
  localparam logic [11:0] M_PRES = 12'h020;
  localparam logic [11:0] M_ST   = 12'h01C;
  localparam logic [11:0] M_RTY  = 12'h003;
  localparam logic [11:0] M_STAT = M_INT | M_PRES | M_ST | M_RTY;

  // Pin patterns {resetl, lpmode, modsell, refclk_reset, clock_ok}.
  localparam logic [11:0] P_ABS   = {5'b01110, 7'b0};
  localparam logic [11:0] P_MRST  = {5'b01100, 7'b0};
  localparam logic [11:0] P_INIT  = {5'b11100, 7'b0};
  localparam logic [11:0] P_RUN   = {5'b10001, 7'b0};
  localparam logic [11:0] P_FAULT = {5'b01100, 7'b0};

  typedef struct {
    int          cyc;
    string       nm;
    logic [11:0] mask;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [11:0] st(input logic [2:0] s);
    return {7'b0, s, 2'b0};
  endfunction

  function automatic void push(input int c, input string nm, input logic [11:0] m,
                               input logic [11:0] v);
    exp_t e;
    e.cyc  = c;
    e.nm   = nm;
    e.mask = m;
    e.val  = v;
    sb.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic until_edge(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: compare every expectation due at this cycle.
  exp_t me;
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      me = sb.pop_front();
      vectors++;
      if (me.cyc != cyc || (obs & me.mask) != me.val) begin
        miscompares++;
        $display("FAIL %s: due cycle %0d checked cycle %0d observed %03h expected %03h (mask %03h)",
                 me.nm, me.cyc, cyc, obs & me.mask, me.val, me.mask);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    resetn = 1'b0; qsfp_modprsl = 1'b0; qsfp_intl = 1'b1; phy_lock = 1'b0;
    int_clear = 1'b0; retry_clear = 1'b0;
    tick(3);
    vectors++;
    if ((obs & M_PINS) != P_ABS) begin
      miscompares++;
      $display("FAIL in_reset_pins: observed %03h expected %03h", obs & M_PINS, P_ABS);
    end
    vectors++;
    if ((obs & M_STAT) != 12'h000) begin
      miscompares++;
      $display("FAIL in_reset_status: observed %03h expected 000", obs & M_STAT);
    end
    push(cyc, "reset_pins", M_PINS, P_ABS);
    push(cyc, "reset_status", M_STAT, 12'h000);
    resetn = 1'b1;

    // Power-up with module present from reset; lock two cycles into PHY_START.
    b = cyc;
    push(b + 5,  "pres_not_yet", M_PRES | M_ST, st(0));
    push(b + 6,  "pres_rise", M_PRES | M_ST, M_PRES | st(0));
    push(b + 7,  "refclk_enter", M_PINS | M_ST, P_ABS | st(1));
    push(b + 9,  "refclk_last", M_ST, st(1));
    push(b + 10, "modrst_enter", M_PINS | M_ST, P_MRST | st(2));
    push(b + 14, "modrst_last", M_ST, st(2));
    push(b + 15, "init_enter", M_PINS | M_ST, P_INIT | st(3));
    push(b + 24, "init_last", M_ST, st(3));
    push(b + 25, "phy_start", M_PINS | M_ST, P_RUN | st(4));
    push(b + 29, "lock_in_sync", M_ST, st(4));
    push(b + 30, "up", M_PINS | M_ST | M_RTY, P_RUN | st(5));
    until_edge(b + 27); phy_lock = 1'b1;
    until_edge(b + 31);

    // Interrupt latch in UP.
    b = cyc;
    push(b + 2, "int_sync_wait", M_INT, 12'h000);
    push(b + 3, "int_set", M_INT, M_INT);
    push(b + 6, "int_sticky", M_INT | M_ST, M_INT | st(5));
    qsfp_intl = 1'b0; until_edge(b + 1); qsfp_intl = 1'b1;
    until_edge(b + 6);
    b = cyc;
    push(b + 3, "int_set_beats_clear", M_INT, M_INT);
    push(b + 4, "int_still_set", M_INT, M_INT);
    push(b + 5, "int_before_clear", M_INT, M_INT);
    push(b + 6, "int_cleared", M_INT, 12'h000);
    qsfp_intl = 1'b0; until_edge(b + 1); qsfp_intl = 1'b1;
    until_edge(b + 2); int_clear = 1'b1;
    until_edge(b + 3); int_clear = 1'b0;
    until_edge(b + 5); int_clear = 1'b1;
    until_edge(b + 6); int_clear = 1'b0;
    until_edge(b + 7);

    // Removal from UP with lock lost and an interrupt pending.
    b = cyc;
    push(b + 3, "rm_int_set", M_INT, M_INT);
    push(b + 6, "rm_pres_fall_still_up", M_PRES | M_ST | M_INT, M_INT | st(5));
    push(b + 7, "rm_absent", M_PINS | M_STAT, P_ABS | st(0));
    qsfp_modprsl = 1'b1; phy_lock = 1'b0; qsfp_intl = 1'b0;
    until_edge(b + 1); qsfp_intl = 1'b1;
    until_edge(b + 8);

    // Glitch: three low samples must not assert presence.
    b = cyc;
    push(b + 6, "glitch_pres", M_PRES | M_ST, st(0));
    push(b + 9, "glitch_hold", M_PINS | M_PRES | M_ST, P_ABS | st(0));
    qsfp_modprsl = 1'b0; until_edge(b + 3); qsfp_modprsl = 1'b1;
    until_edge(b + 10);

    // Re-insert, then remove during MOD_INIT.
    b = cyc;
    push(b + 15, "reins_init", M_PINS | M_ST, P_INIT | st(3));
    push(b + 22, "init_rm_pres", M_PRES | M_ST, st(3));
    push(b + 23, "init_rm_absent", M_PINS | M_ST | M_RTY, P_ABS | st(0));
    qsfp_modprsl = 1'b0; until_edge(b + 16); qsfp_modprsl = 1'b1;
    until_edge(b + 24);

    // Lock timeout: two retries, then FAULT, then retry_clear; async reset in PHY_START.
    b = cyc;
    push(b + 25, "lt_phy0", M_ST | M_RTY, st(4));
    push(b + 32, "lt_phy0_last", M_ST, st(4));
    push(b + 33, "lt_retry1", M_PINS | M_ST | M_RTY, P_MRST | st(2) | 12'd1);
    push(b + 48, "lt_phy1", M_ST | M_RTY, st(4) | 12'd1);
    push(b + 56, "lt_retry2", M_ST | M_RTY, st(2) | 12'd2);
    push(b + 71, "lt_phy2", M_PINS | M_ST, P_RUN | st(4));
    push(b + 78, "lt_phy2_last", M_ST, st(4));
    push(b + 79, "lt_fault", M_PINS | M_ST | M_RTY, P_FAULT | st(6) | 12'd2);
    push(b + 81, "fault_hold", M_ST, st(6));
    push(b + 82, "retry_clear", M_PINS | M_ST | M_RTY, P_MRST | st(2));
    push(b + 97, "phy_again", M_PINS | M_ST, P_RUN | st(4));
    push(b + 99, "async_rst_pins", M_PINS, P_ABS);
    push(b + 99, "async_rst_status", M_STAT, 12'h000);
    qsfp_modprsl = 1'b0;
    until_edge(b + 81); retry_clear = 1'b1;
    until_edge(b + 82); retry_clear = 1'b0;
    until_edge(b + 99); resetn = 1'b0;
    #1;
    vectors++;
    if ((obs & M_PINS) != P_ABS) begin
      miscompares++;
      $display("FAIL async_rst_immediate_pins: observed %03h expected %03h", obs & M_PINS, P_ABS);
    end
    vectors++;
    if ((obs & M_STAT) != 12'h000) begin
      miscompares++;
      $display("FAIL async_rst_immediate_status: observed %03h expected 000", obs & M_STAT);
    end
    until_edge(b + 102); resetn = 1'b1;
    tick(2);

    while (sb.size() > 0) begin
      me = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: never checked, due cycle %0d expected %03h", me.nm, me.cyc, me.val);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0) $display("TEST FAILED");
    else                  $display("TEST PASSED");
    $finish;
  end

endmodule
